// File: rtl/q_update_controller.sv
`default_nettype none
// ============================================================================
// Module   : q_update_controller
// Brief    : Sequences one shift-based Q-learning update on a single-port Q-table.
// Revision : 1.0
// ============================================================================
module q_update_controller #(
    parameter int ROWS        = 5,
    parameter int COLS        = 5,
    parameter int ACTIONS     = 4,
    parameter int ADDR_WIDTH  = 7,
    parameter int DATA_WIDTH  = 8,
    parameter int ALPHA_SHIFT = 2,
    parameter int GAMMA_SHIFT = 3
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         req_valid,
    output logic                         req_ready,
    input  logic [2:0]                   row,
    input  logic [2:0]                   col,
    input  logic [1:0]                   action,
    input  logic [2:0]                   next_row,
    input  logic [2:0]                   next_col,
    input  logic signed [DATA_WIDTH-1:0] reward,
    input  logic                         terminal,
    output logic                         mem_en,
    output logic                         mem_we,
    output logic [ADDR_WIDTH-1:0]        mem_addr,
    output logic [DATA_WIDTH-1:0]        mem_wdata,
    input  logic [DATA_WIDTH-1:0]        mem_rdata,
    output logic                         done,
    output logic                         error,
    output logic [DATA_WIDTH-1:0]        q_new,
    output logic [1:0]                   best_action
);

    localparam int c_iw = DATA_WIDTH + 3;

    localparam logic [2:0] c_st_idle    = 3'd0;
    localparam logic [2:0] c_st_rd_sa   = 3'd1;
    localparam logic [2:0] c_st_rd_next = 3'd2;
    localparam logic [2:0] c_st_rd_last = 3'd3;
    localparam logic [2:0] c_st_calc    = 3'd4;
    localparam logic [2:0] c_st_write   = 3'd5;
    localparam logic [2:0] c_st_done    = 3'd6;

    localparam logic [2:0]              c_rows     = 3'(ROWS);
    localparam logic [2:0]              c_cols     = 3'(COLS);
    localparam logic [1:0]              c_last_k   = 2'(ACTIONS - 1);
    localparam logic [ADDR_WIDTH-1:0]   c_addr_one = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
    localparam logic signed [c_iw-1:0]  c_qmax     = c_iw'((2 ** (DATA_WIDTH - 1)) - 1);
    localparam logic signed [c_iw-1:0]  c_qmin     = ~c_qmax;

    logic [2:0]                   r_state;
    logic [1:0]                   r_k;
    logic [ADDR_WIDTH-1:0]        r_addr_sa;
    logic [ADDR_WIDTH-1:0]        r_next_base;
    logic signed [DATA_WIDTH-1:0] r_reward;
    logic                         r_terminal;
    logic signed [DATA_WIDTH-1:0] r_q_sa;
    logic signed [DATA_WIDTH-1:0] r_maxq;
    logic [1:0]                   r_best;

    logic                         w_range_err;
    logic signed [c_iw-1:0]       w_maxq_x, w_reward_x, w_qsa_x;
    logic signed [c_iw-1:0]       w_g, w_target, w_delta, w_sum;
    logic [DATA_WIDTH-1:0]        w_q_sat;

    function automatic logic [ADDR_WIDTH-1:0] f_addr(input logic [2:0] r,
                                                     input logic [2:0] c,
                                                     input logic [1:0] a);
        int unsigned v;
        v = (int'(r) * COLS + int'(c)) * ACTIONS + int'(a);
        return v[ADDR_WIDTH-1:0];
    endfunction

    // Next-state coordinates are irrelevant when the episode ends there.
    assign w_range_err = (row >= c_rows) || (col >= c_cols) ||
                         (!terminal && ((next_row >= c_rows) || (next_col >= c_cols)));

    assign w_maxq_x   = {{3{r_maxq[DATA_WIDTH-1]}}, r_maxq};
    assign w_reward_x = {{3{r_reward[DATA_WIDTH-1]}}, r_reward};
    assign w_qsa_x    = {{3{r_q_sa[DATA_WIDTH-1]}}, r_q_sa};
    assign w_g        = w_maxq_x - (w_maxq_x >>> GAMMA_SHIFT);
    assign w_target   = w_reward_x + w_g;
    assign w_delta    = w_target - w_qsa_x;
    assign w_sum      = w_qsa_x + (w_delta >>> ALPHA_SHIFT);
    assign w_q_sat    = (w_sum > c_qmax) ? c_qmax[DATA_WIDTH-1:0] :
                        (w_sum < c_qmin) ? c_qmin[DATA_WIDTH-1:0] : w_sum[DATA_WIDTH-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_st_idle;
            r_k         <= '0;
            r_addr_sa   <= '0;
            r_next_base <= '0;
            r_reward    <= '0;
            r_terminal  <= 1'b0;
            r_q_sa      <= '0;
            r_maxq      <= '0;
            r_best      <= '0;
            req_ready   <= 1'b1;
            mem_en      <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            done        <= 1'b0;
            error       <= 1'b0;
            q_new       <= '0;
            best_action <= '0;
        end else begin
            mem_en <= 1'b0;
            mem_we <= 1'b0;
            done   <= 1'b0;
            case (r_state)
                c_st_idle: begin
                    if (req_valid && req_ready) begin
                        req_ready   <= 1'b0;
                        r_addr_sa   <= f_addr(row, col, action);
                        r_next_base <= f_addr(next_row, next_col, 2'd0);
                        r_reward    <= reward;
                        r_terminal  <= terminal;
                        r_k         <= '0;
                        r_maxq      <= '0;
                        r_best      <= '0;
                        if (w_range_err) begin
                            r_state     <= c_st_done;
                            done        <= 1'b1;
                            error       <= 1'b1;
                            q_new       <= '0;
                            best_action <= '0;
                        end else begin
                            r_state  <= c_st_rd_sa;
                            mem_en   <= 1'b1;
                            mem_addr <= f_addr(row, col, action);
                        end
                    end
                end
                c_st_rd_sa: begin
                    if (r_terminal) begin
                        r_state <= c_st_rd_last;
                    end else begin
                        r_state  <= c_st_rd_next;
                        mem_en   <= 1'b1;
                        mem_addr <= r_next_base;
                    end
                end
                c_st_rd_next: begin
                    // Data arriving now belongs to the read issued one cycle earlier.
                    if (r_k == 2'd0) begin
                        r_q_sa <= $signed(mem_rdata);
                    end else if ((r_k == 2'd1) || ($signed(mem_rdata) > r_maxq)) begin
                        r_maxq <= $signed(mem_rdata);
                        r_best <= r_k - 2'd1;
                    end
                    if (r_k == c_last_k) begin
                        r_state <= c_st_rd_last;
                    end else begin
                        r_k      <= r_k + 2'd1;
                        mem_en   <= 1'b1;
                        mem_addr <= mem_addr + c_addr_one;
                    end
                end
                c_st_rd_last: begin
                    if (r_terminal) begin
                        r_q_sa <= $signed(mem_rdata);
                    end else if ($signed(mem_rdata) > r_maxq) begin
                        r_maxq <= $signed(mem_rdata);
                        r_best <= c_last_k;
                    end
                    r_state <= c_st_calc;
                end
                c_st_calc: begin
                    r_state   <= c_st_write;
                    mem_en    <= 1'b1;
                    mem_we    <= 1'b1;
                    mem_addr  <= r_addr_sa;
                    mem_wdata <= w_q_sat;
                end
                c_st_write: begin
                    r_state     <= c_st_done;
                    done        <= 1'b1;
                    error       <= 1'b0;
                    q_new       <= mem_wdata;
                    best_action <= r_best;
                end
                c_st_done: begin
                    r_state   <= c_st_idle;
                    req_ready <= 1'b1;
                end
                default: begin
                    r_state   <= c_st_idle;
                    req_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/q_update_controller.md
Name: q_update_controller

Overview:
- Sequences one Q-learning update against a single-port Q-table RAM.
- Accepts a request (state, action, next state, reward) over a valid/ready handshake.
- Reads Q(s,a) and Q(s',0..ACTIONS-1), finds max and greedy action, computes the shift-based update, writes back, and pulses done.
- Sits between the agent/environment stepper and the Q-table memory; it is the only master of that memory port.

Parameters:
- ROWS, 5, grid rows
- COLS, 5, grid columns
- ACTIONS, 4, actions per state
- ADDR_WIDTH, 7, Q-table address width
- DATA_WIDTH, 8, signed Q-value/reward width
- ALPHA_SHIFT, 2, learning rate alpha = 2^-ALPHA_SHIFT
- GAMMA_SHIFT, 3, discount: gamma*x = x - (x >>> GAMMA_SHIFT)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- req_valid  in  1  update request
- req_ready  out  1  high only in IDLE
- row, col  in  3 each  current state
- action  in  2  action taken
- next_row, next_col  in  3 each  next state
- reward  in  DATA_WIDTH  signed reward
- terminal  in  1  next state terminal; max Q forced to 0
- mem_en  out  1  memory access strobe
- mem_we  out  1  write enable (valid with mem_en)
- mem_addr  out  ADDR_WIDTH  address
- mem_wdata  out  DATA_WIDTH  write data
- mem_rdata  in  DATA_WIDTH  read data, valid the cycle after a read strobe
- done  out  1  one-cycle completion pulse
- error  out  1  valid with done; request out of range
- q_new  out  DATA_WIDTH  written value, valid with done
- best_action  out  2  argmax over next-state actions, valid with done

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high.
- Reset: IDLE; req_ready=1; mem_en, mem_we, done, error = 0; mem_addr, mem_wdata, q_new, best_action = 0.
- Addressing: addr(r,c,a) = (r*COLS + c)*ACTIONS + a.
- Accept: request accepted on the edge where req_valid && req_ready. All inputs are latched; later changes are ignored until the next IDLE.
- FSM, with cycle N = accept edge:
  - IDLE -> RD_SA (N+1): read addr(row,col,action).
  - RD_NEXT k=0..ACTIONS-1 (N+2..N+5): read addr(next_row,next_col,k). Capture the previous read's rdata each cycle.
  - RD_LAST (N+6): capture the last rdata; mem_en=0.
  - CALC (N+7).
  - WRITE (N+8): mem_en=1, mem_we=1, mem_wdata=q_new.
  - DONE (N+9): done=1, then IDLE.
- Terminal path: RD_SA -> RD_LAST -> CALC -> WRITE -> DONE. done at N+5; maxq=0; best_action=0.
- Range error: row>=ROWS, col>=COLS, next_row>=ROWS or next_col>=COLS (next checked only if terminal=0). Path is IDLE -> DONE, with done=error=1 at N+1, q_new=0, and no memory access.
- Max search: strict greater-than compare, so ties resolve to the lowest action index.
- Arithmetic: signed, DATA_WIDTH+3 bits internal, arithmetic shifts.
  - g = maxq - (maxq >>> GAMMA_SHIFT)
  - target = reward + g
  - delta = target - q_sa
  - q_new = sat(q_sa + (delta >>> ALPHA_SHIFT)), saturated to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1]
- Throughput: req_ready rises in the cycle after DONE. req_valid held high gives back-to-back updates every 10 cycles (ACTIONS=4).
- Reset mid-operation: the rst edge forces IDLE. No write is issued after rst is sampled high, and memory contents already written are untouched.
- mem_en=0 in IDLE, DONE and RD_LAST. mem_we=1 only in WRITE.

Test Plan:
- All memory zero; req (0,0,a0) -> next (1,1), reward 8 -> read addr 0, then 24..27. Write addr 0 with 2 at N+8; done at N+9; q_new=2, best_action=0, error=0.
- addr 11 (0,2,a3)=16; addrs 24..27 = 10,40,-5,40; reward 4 -> g=35, target 39, delta 23, q_new=21 written to 11; best_action=1 (tie).
- Saturation cases:
  - q_sa=127, all next=127, reward 127 -> q_new=127.
  - q_sa=-128, all next=-128, reward -128 -> q_new=-128.
- terminal=1, q_sa=20, reward -8 -> exactly one read and one write; q_new=13; done at N+5.
- row=5 -> done and error at N+1; q_new=0; mem_en never asserted; req_ready=1 at N+2.
- rst asserted for one cycle during CALC -> no write strobe, memory unchanged, req_ready=1 and all outputs at reset values; a following request completes normally.
